// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - round-robin sharing of one pipelined adder among N requesters
// Optional ADD_ARB_OVF_EN adds rsp_ovf, the carry-out of each issued sum.
module adder_share_arb #(
  parameter int N   = 4,
  parameter int W   = 16,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   req_ready,
  output logic           add_start,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  input  logic [W-1:0]   add_y,
  input  logic           add_valid,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           busy,
  output logic           err_spurious
`ifdef ADD_ARB_OVF_EN
  ,
  output logic           rsp_ovf
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win;
  logic          grant;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;
  logic [LAT:0]  tag_vld;
  logic [IW-1:0] tag_id [0:LAT];
  logic          hit;

  // Rotating priority search starting at rr_ptr; reset also blocks grants.
  always_comb begin
    logic [IW-1:0] cand;
    grant = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(rr_ptr) + k) % N);
      if (!grant && req_valid[cand]) begin
        grant = 1'b1;
        win   = cand;
      end
    end
    grant = grant & enable & ~rst;
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_ready[i] = grant && (win == IW'(i));
    end
  end

  assign sel_a = req_a[win*W +: W];
  assign sel_b = req_b[win*W +: W];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      add_start    <= 1'b0;
      add_a        <= '0;
      add_b        <= '0;
      tag_vld      <= '0;
      err_spurious <= 1'b0;
    end else begin
      add_start <= grant;
      if (grant) begin
        add_a  <= sel_a;
        add_b  <= sel_b;
        rr_ptr <= (win == IW'(N-1)) ? '0 : win + 1'b1;
      end
      // Stage 0 loads alongside add_start, so stage LAT lines up with add_valid.
      tag_vld <= {tag_vld[LAT-1:0], grant};
      if (add_valid && !tag_vld[LAT]) begin
        err_spurious <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= win;
    for (int k = 1; k <= LAT; k++) begin
      tag_id[k] <= tag_id[k-1];
    end
  end

  assign hit = add_valid & tag_vld[LAT];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      rsp_valid[i] = hit && (tag_id[LAT] == IW'(i));
    end
    rsp_data = hit ? add_y : '0;
  end

  assign busy = (|tag_vld) | add_start;

`ifdef ADD_ARB_OVF_EN
  logic [W-1:0] sel_sum;
  logic [LAT:0] tag_cy;

  // Modulo sum smaller than an operand means the add wrapped.
  assign sel_sum = sel_a + sel_b;

  always_ff @(posedge clk) begin
    tag_cy <= {tag_cy[LAT-1:0], (sel_sum < sel_a)};
  end

  assign rsp_ovf = hit & tag_cy[LAT];
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// tb/tb_adder_share_arb.sv - randomized and directed bench for adder_share_arb
// Build with ADD_ARB_OVF_EN defined to also check rsp_ovf.
module tb_adder_share_arb;
  localparam int N   = 4;
  localparam int W   = 16;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           add_start;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_y;
  logic           add_valid;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           busy;
  logic           err_spurious;
`ifdef ADD_ARB_OVF_EN
  logic           rsp_ovf;
`endif

  always #5 clk = ~clk;

  adder_share_arb #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .add_start    (add_start),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_y        (add_y),
    .add_valid    (add_valid),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .err_spurious (err_spurious)
`ifdef ADD_ARB_OVF_EN
    ,
    .rsp_ovf      (rsp_ovf)
`endif
  );

  // External pipelined adder, sharing the reset; force_v injects a stray valid.
  logic [LAT-1:0] ap_v;
  logic [W-1:0]   ap_y [LAT];
  logic           force_v;
  logic [W-1:0]   force_y;

  always @(posedge clk) begin
    if (rst) begin
      ap_v <= '0;
    end else begin
      ap_v <= {ap_v[LAT-2:0], add_start};
    end
    ap_y[0] <= add_a + add_b;
    for (int k = 1; k < LAT; k++) ap_y[k] <= ap_y[k-1];
  end

  assign add_valid = ap_v[LAT-1] | force_v;
  assign add_y     = force_v ? force_y : ap_y[LAT-1];

  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] sum;
    logic         cy;
  } exp_t;

  exp_t         q[$];
  int           cyc;
  int           mptr;
  int           start_due;
  logic         m_err;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  int           errors;
  int           checks;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Checks one cycle against the reference, then advances the model and the clock.
  task automatic step();
    int           g;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    logic [W-1:0] exp_d;
    logic         exp_o;
    logic [W:0]   full;
    exp_t         e;
    g = -1;
    exp_ready = '0;
    exp_rv = '0;
    exp_d = '0;
    exp_o = 1'b0;
    #1;
    if (enable && !rst) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    chk("add_start", add_start, start_due == cyc);
    chk("add_a", add_a, m_a);
    chk("add_b", add_b, m_b);
    chk("busy", busy, q.size() > 0);
    chk("err_spurious", err_spurious, m_err);
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_rv[q[0].id] = 1'b1;
      exp_d = q[0].sum;
      exp_o = q[0].cy;
      void'(q.pop_front());
    end
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rsp_data", rsp_data, exp_d);
`ifdef ADD_ARB_OVF_EN
    chk("rsp_ovf", rsp_ovf, exp_o);
`endif
    if (force_v) m_err = 1'b1;
    if (g >= 0) begin
      full  = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]};
      e.due = cyc + 1 + LAT;
      e.id  = g;
      e.sum = full[W-1:0];
      e.cy  = full[W];
      q.push_back(e);
      mptr      = (g + 1) % N;
      start_due = cyc + 1;
      m_a       = req_a[g*W +: W];
      m_b       = req_b[g*W +: W];
    end
    if (rst) begin
      q.delete();
      mptr      = 0;
      start_due = -1;
      m_err     = 1'b0;
      m_a       = '0;
      m_b       = '0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    mptr = 0;
    start_due = -1;
    m_err = 1'b0;
    m_a = '0;
    m_b = '0;
    rst = 1'b1;
    enable = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    force_v = 1'b0;
    force_y = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Single request from requester 0: 3 + 5
    enable = 1'b1;
    set_op(0, 16'd3, 16'd5);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (4) step();

    // All four requesting continuously with a=i, b=10*i
    for (int i = 0; i < N; i++) set_op(i, W'(i), W'(10 * i));
    req_valid = 4'b1111;
    repeat (5) step();
    req_valid = '0;
    repeat (4) step();

    // Wrap-around on requester 2
    set_op(2, 16'hFFFF, 16'h0002);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    repeat (4) step();

    // Two back-to-back grants, then enable dropped with requests pending
    req_valid = 4'b1111;
    repeat (2) step();
    enable = 1'b0;
    repeat (6) step();
    enable = 1'b1;
    repeat (2) step();
    req_valid = '0;
    repeat (4) step();

    // Reset pulsed one cycle after an issue
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();
    req_valid = 4'b1111;
    step();
    req_valid = '0;
    repeat (4) step();

    // Stray adder valid with nothing in flight
    force_v = 1'b1;
    force_y = 16'h1234;
    step();
    force_v = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Random traffic with occasional enable drops and resets
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom % 8) != 0;
      rst = ($urandom % 80) == 0;
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
      step();
    end
    rst = 1'b0;
    req_valid = '0;
    repeat (LAT + 3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
